// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared state encoding and helpers for the LED share scheduler. Rev 1.0
`default_nettype none

package led_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int MAX_REQ = 8;

  // Ceiling log2 that never returns less than one bit, so every counter stays declarable.
  function automatic int clog2w(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // First set request bit at or after ptr, wrapping modulo n; returns ptr if none set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int   win;
    int   idx;
    logic found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (ptr + i) % n;
      if (!found && (i < n) && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by DIV into a one-cycle tick, restartable via clr_i. Rev 1.0
`default_nettype none

module tick_prescaler
  import led_sched_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = clog2w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/led_share_scheduler.sv
// led_share_scheduler: round-robin time sharing of the LED bank with dwell, gap and blink. Rev 1.0
`default_nettype none

module led_share_scheduler
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1_000,
  parameter int NUM_REQ     = 4,
  parameter int LED_W       = 4,
  parameter int DWELL_TICKS = 250,
  parameter int GAP_TICKS   = 10,
  parameter int BLINK_TICKS = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LED_W-1:0] pattern_i,
  input  logic [NUM_REQ-1:0]       blink_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [LED_W-1:0]         led_o,
  output logic                     busy_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = clog2w(max3(DWELL_TICKS, GAP_TICKS, BLINK_TICKS) + 1);
  localparam int PW  = clog2w(NUM_REQ);

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_TICKS - 1);
  localparam logic [PW-1:0] REQ_LAST   = PW'(NUM_REQ - 1);

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      gidx_q, gidx_d;
  logic [LED_W-1:0]   pat_q, pat_d;
  logic               blk_q, blk_d;
  logic               phase_q, phase_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [TW-1:0]      bcnt_q, bcnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [PW-1:0]      win;
  logic               tick;
  logic               clr;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .tick_o (tick)
  );

  assign win = PW'(rr_pick(MAX_REQ'(req_i), int'(ptr_q), NUM_REQ));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    pat_d   = pat_q;
    blk_d   = blk_q;
    phase_d = phase_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_SHOW;
          gidx_d  = win;
          pat_d   = pattern_i[win*LED_W +: LED_W];
          blk_d   = blink_i[win];
          phase_d = 1'b1;
          tcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      ST_SHOW: begin
        if (tick) begin
          tcnt_d = tcnt_q + TW'(1);
          if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            bcnt_d = bcnt_q + TW'(1);
          end
        end
        // Dwell expiry and release landing together collapse into this single exit.
        if ((tick && (tcnt_q == DWELL_LAST)) || !req_i[gidx_q]) begin
          state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
          tcnt_d  = '0;
          ptr_d   = (gidx_q == REQ_LAST) ? '0 : gidx_q + PW'(1);
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (tcnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clr     = (state_d != state_q);
    grant_d = '0;
    led_d   = '0;
    // Outputs follow the next state so grant and led switch on the same edge as the FSM.
    if (state_d == ST_SHOW) begin
      grant_d[gidx_d] = 1'b1;
      led_d           = (blk_d && !phase_d) ? '0 : pat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      pat_q   <= '0;
      blk_q   <= 1'b0;
      phase_q <= 1'b1;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      grant_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      pat_q   <= pat_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      grant_q <= grant_d;
      led_q   <= led_d;
    end
  end

  assign grant_o = grant_q;
  assign led_o   = led_q;
  assign busy_o  = (state_q != ST_IDLE);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_q));
  a_dark_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (grant_q == '0) |-> (led_q == '0));
  a_single_grant: assert property (@(posedge clk) disable iff (!rst_n)
    ((grant_q != '0) && ($past(grant_q) != '0)) |-> (grant_q == $past(grant_q)));

endmodule

`default_nettype wire

// File: tb/tb_led_share_scheduler.sv
// tb_led_share_scheduler: directed self-checking bench for led_share_scheduler. Rev 1.0
`default_nettype none

module tb_led_share_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [15:0] pattern = 16'h0;
  logic [3:0]  blink = 4'h0;
  logic [3:0]  grant;
  logic [3:0]  led;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_share_scheduler #(
    .CLK_HZ      (1000),
    .TICK_HZ     (100),
    .NUM_REQ     (4),
    .LED_W       (4),
    .DWELL_TICKS (3),
    .GAP_TICKS   (2),
    .BLINK_TICKS (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .pattern_i (pattern),
    .blink_i   (blink),
    .grant_o   (grant),
    .led_o     (led),
    .busy_o    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks outputs for n consecutive samples, advancing one clock after each.
  task automatic expect_run(input string tag, input logic [3:0] g, input logic [3:0] l,
                            input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].grant", tag, i), 32'(grant), 32'(g));
      check($sformatf("%s[%0d].led", tag, i), 32'(led), 32'(l));
      check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(b));
      step();
    end
  endtask

  initial begin
    // T1: reset held with every requester asking.
    rst_n   = 1'b0;
    req     = 4'hF;
    pattern = 16'h8421;
    blink   = 4'h0;
    repeat (3) step();
    check("t1_rst.grant", 32'(grant), 32'h0);
    check("t1_rst.led", 32'(led), 32'h0);
    check("t1_rst.busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T1 + T3: first edge grants requester 0, then round robin 1,2,4,8,1.
    for (int k = 0; k < 4; k++) begin
      expect_run($sformatf("t3_show%0d", k), 4'(1 << k), 4'(1 << k), 1'b1, 30);
      expect_run($sformatf("t3_gap%0d", k), 4'h0, 4'h0, 1'b1, 20);
      expect_run($sformatf("t3_idle%0d", k), 4'h0, 4'h0, 1'b0, 1);
    end
    expect_run("t3_wrap", 4'h1, 4'h1, 1'b1, 1);
    req = 4'h0;
    expect_run("t3_drop", 4'h1, 4'h1, 1'b1, 1);
    expect_run("t3_gapend", 4'h0, 4'h0, 1'b1, 20);
    expect_run("t3_idle", 4'h0, 4'h0, 1'b0, 2);

    // T2: single requester 1, latched pattern survives input changes, then regrant.
    req     = 4'b0010;
    pattern = 16'h84A1;
    step();
    expect_run("t2_show", 4'h2, 4'hA, 1'b1, 10);
    pattern = 16'h0000;
    blink   = 4'hF;
    expect_run("t2_hold", 4'h2, 4'hA, 1'b1, 20);
    pattern = 16'h84A1;
    blink   = 4'h0;
    expect_run("t2_gap", 4'h0, 4'h0, 1'b1, 20);
    expect_run("t2_idle", 4'h0, 4'h0, 1'b0, 1);
    expect_run("t2_regrant", 4'h2, 4'hA, 1'b1, 1);
    req = 4'h0;
    expect_run("t2_drop", 4'h2, 4'hA, 1'b1, 1);
    expect_run("t2_gap2", 4'h0, 4'h0, 1'b1, 20);
    expect_run("t2_idle2", 4'h0, 4'h0, 1'b0, 1);

    // T4: early release at SHOW cycle 7.
    req     = 4'b0001;
    pattern = 16'h000F;
    step();
    expect_run("t4_show", 4'h1, 4'hF, 1'b1, 7);
    req = 4'h0;
    expect_run("t4_last", 4'h1, 4'hF, 1'b1, 1);
    expect_run("t4_gap", 4'h0, 4'h0, 1'b1, 20);
    expect_run("t4_idle", 4'h0, 4'h0, 1'b0, 1);

    // T5: blinking requester 2, then sole-requester regrant.
    req     = 4'b0100;
    pattern = 16'h0500;
    blink   = 4'b0100;
    step();
    expect_run("t5_on0", 4'h4, 4'h5, 1'b1, 10);
    expect_run("t5_off", 4'h4, 4'h0, 1'b1, 10);
    expect_run("t5_on1", 4'h4, 4'h5, 1'b1, 10);
    expect_run("t5_gap", 4'h0, 4'h0, 1'b1, 20);
    expect_run("t5_idle", 4'h0, 4'h0, 1'b0, 1);

    // T6: asynchronous reset at SHOW cycle 15 of the regrant.
    expect_run("t6_on", 4'h4, 4'h5, 1'b1, 10);
    expect_run("t6_off", 4'h4, 4'h0, 1'b1, 5);
    req     = 4'b1010;
    pattern = 16'h0030;
    blink   = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async.grant", 32'(grant), 32'h0);
    check("t6_async.led", 32'(led), 32'h0);
    check("t6_async.busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_run("t6_restart", 4'h2, 4'h3, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
